// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encoding and defaults for the bit-serial subtractor
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DONE   = 2'd2,
    ST_UNUSED = 2'd3
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - combinational one-bit full subtractor cell
module full_subtractor (
  input  logic in_1,
  input  logic in_2,
  input  logic b_in,
  output logic diff,
  output logic b_out
);

  assign diff  = in_1 ^ in_2 ^ b_in;
  assign b_out = (~in_1 & in_2) | (~(in_1 ^ in_2) & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first bit-serial subtractor with start/busy/done handshake
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_d_sr;
  logic [WIDTH-1:0] r_diff;
  logic             r_bor;
  logic             r_b_out;
  logic [CW-1:0]    r_cnt;
  logic             w_d;
  logic             w_bor;
  logic             w_last;

  full_subtractor u_fs (
    .in_1  (r_a_sr[0]),
    .in_2  (r_b_sr[0]),
    .b_in  (r_bor),
    .diff  (w_d),
    .b_out (w_bor)
  );

  assign w_last = (r_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE: w_next = start ? ST_RUN : ST_IDLE;
      ST_RUN:  w_next = w_last ? ST_DONE : ST_RUN;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // The counter parks at its last value instead of wrapping; IDLE clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_d_sr  <= '0;
      r_diff  <= '0;
      r_bor   <= 1'b0;
      r_b_out <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a_sr <= in_1;
            r_b_sr <= in_2;
            r_bor  <= b_in;
            r_cnt  <= '0;
          end
        end
        ST_RUN: begin
          r_a_sr <= r_a_sr >> 1;
          r_b_sr <= r_b_sr >> 1;
          r_bor  <= w_bor;
          r_d_sr <= {w_d, r_d_sr[WIDTH-1:1]};
          if (w_last) begin
            r_diff  <= {w_d, r_d_sr[WIDTH-1:1]};
            r_b_out <= w_bor;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy  = (r_state == ST_RUN);
  assign done  = (r_state == ST_DONE);
  assign diff  = r_diff;
  assign b_out = r_b_out;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and model-based bench for serial_subtractor at WIDTH 4 and 8
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start4, bi4, busy4, done4, bo4;
  logic [3:0] a4, b4, diff4;
  logic       start8, bi8, busy8, done8, bo8;
  logic [7:0] a8, b8, diff8;
  logic       sel8;
  logic       busy_s, done_s, bo_s;
  logic [7:0] diff_s;

  int n_checks = 0;
  int n_errors = 0;

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .in_1(a4), .in_2(b4), .b_in(bi4),
    .busy(busy4), .done(done4), .diff(diff4), .b_out(bo4)
  );

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .in_1(a8), .in_2(b8), .b_in(bi8),
    .busy(busy8), .done(done8), .diff(diff8), .b_out(bo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    busy_s = sel8 ? busy8 : busy4;
    done_s = sel8 ? done8 : done4;
    bo_s   = sel8 ? bo8 : bo4;
    diff_s = sel8 ? diff8 : {4'b0, diff4};
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       input logic [7:0] exp_d, input logic exp_bo, input string tag);
    int n;
    int busy_n;
    int w;
    w = sel8 ? 8 : 4;
    n = 0;
    while ((busy_s || done_s) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (sel8) begin
      a8 = a; b8 = b; bi8 = bi; start8 = 1'b1;
    end else begin
      a4 = a[3:0]; b4 = b[3:0]; bi4 = bi; start4 = 1'b1;
    end
    @(posedge clk); #1;
    start4 = 1'b0;
    start8 = 1'b0;
    n = 0;
    busy_n = 0;
    while (!done_s && n < 20) begin
      if (busy_s) busy_n++;
      @(posedge clk); #1; n++;
    end
    check_val({tag, " latency"}, n, w);
    check_val({tag, " busy cycles"}, busy_n, w);
    check_val({tag, " busy with done"}, {31'b0, busy_s}, 32'd0);
    check_val({tag, " diff"}, {24'b0, diff_s}, {24'b0, exp_d});
    check_val({tag, " b_out"}, {31'b0, bo_s}, {31'b0, exp_bo});
    @(posedge clk); #1;
    check_val({tag, " done width"}, {31'b0, done_s}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nd;
    int t;
    int bad;
    int full;
    int tdone[3];
    logic [3:0] va[3];
    logic [3:0] vb[3];
    logic [3:0] vd[3];
    logic       vbo[3];
    logic [7:0] ra, rb;
    logic       rbi;

    rst_n = 1'b0;
    sel8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bi4 = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bi8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset busy", {31'b0, busy4}, 32'd0);
    check_val("reset done", {31'b0, done4}, 32'd0);
    check_val("reset diff", {28'b0, diff4}, 32'd0);
    check_val("reset b_out", {31'b0, bo4}, 32'd0);
    check_val("reset diff8", {24'b0, diff8}, 32'd0);
    check_val("reset busy8", {31'b0, busy8}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(8'd9,  8'd3, 1'b0, 8'h6, 1'b0, "9-3");
    do_op(8'd3,  8'd9, 1'b0, 8'hA, 1'b1, "3-9");
    do_op(8'd0,  8'd0, 1'b1, 8'hF, 1'b1, "0-0-1");
    do_op(8'd15, 8'd0, 1'b0, 8'hF, 1'b0, "15-0");

    // A second start two steps into RUN must neither restart nor queue.
    a4 = 4'd12; b4 = 4'd5; bi4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a4 = 4'd1; b4 = 4'd1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    nd = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (done4) nd++;
    end
    check_val("repulse done count", nd, 1);
    check_val("repulse diff", {28'b0, diff4}, 32'd7);
    check_val("repulse b_out", {31'b0, bo4}, 32'd0);

    a4 = 4'd9; b4 = 4'd3; bi4 = 1'b1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_val("midreset busy", {31'b0, busy4}, 32'd0);
    check_val("midreset done", {31'b0, done4}, 32'd0);
    check_val("midreset diff", {28'b0, diff4}, 32'd0);
    check_val("midreset b_out", {31'b0, bo4}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done4) nd++;
    end
    check_val("midreset no done", nd, 0);
    do_op(8'd7, 8'd2, 1'b0, 8'h5, 1'b0, "7-2");

    // DONE returns to IDLE, where a held start is taken again, so pulses repeat every WIDTH+2 cycles.
    va[0] = 4'd8;  vb[0] = 4'd1; vd[0] = 4'h7; vbo[0] = 1'b0;
    va[1] = 4'd2;  vb[1] = 4'd6; vd[1] = 4'hC; vbo[1] = 1'b1;
    va[2] = 4'd13; vb[2] = 4'd4; vd[2] = 4'h9; vbo[2] = 1'b0;
    a4 = va[0]; b4 = vb[0]; bi4 = 1'b0; start4 = 1'b1;
    nd = 0;
    bad = 0;
    for (int i = 0; i < 3; i++) tdone[i] = 0;
    for (t = 1; t <= 26; t++) begin
      @(posedge clk); #1;
      if (done4) begin
        if (nd < 3) begin
          tdone[nd] = t;
          check_val("held diff", {28'b0, diff4}, {28'b0, vd[nd]});
          check_val("held b_out", {31'b0, bo4}, {31'b0, vbo[nd]});
          if (nd < 2) begin
            a4 = va[nd + 1];
            b4 = vb[nd + 1];
          end else begin
            start4 = 1'b0;
          end
        end
        nd++;
      end else if (nd > 0 && diff4 !== vd[nd - 1]) begin
        bad++;
      end
    end
    start4 = 1'b0;
    check_val("held done count", nd, 3);
    check_val("held spacing 1", tdone[1] - tdone[0], 6);
    check_val("held spacing 2", tdone[2] - tdone[1], 6);
    check_val("held diff hold", bad, 0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int bi = 0; bi < 2; bi++) begin
          full = a - b - bi;
          do_op(8'(a), 8'(b), 1'(bi), 8'(full & 15), full < 0, "exh4");
        end
      end
    end

    sel8 = 1'b1;
    do_op(8'd0,   8'd255, 1'b1, 8'h00, 1'b1, "0-255-1");
    do_op(8'd255, 8'd255, 1'b0, 8'h00, 1'b0, "255-255");
    for (int i = 0; i < 40; i++) begin
      ra  = 8'($urandom_range(255, 0));
      rb  = 8'($urandom_range(255, 0));
      rbi = 1'($urandom_range(1, 0));
      full = int'(ra) - int'(rb) - int'(rbi);
      do_op(ra, rb, rbi, 8'(full & 255), full < 0, "rand8");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
